// File: rtl/obi_to_axi_bridge.sv
// OBI slave to single-beat AXI4 master bridge with one outstanding transaction.
// Writes drive AW and W together; reads drive AR; each response becomes a one-cycle OBI rvalid.
module obi_to_axi_bridge #(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                AXI_DATA_WIDTH = 32,
  parameter int unsigned                AXI_ID_WIDTH   = 16,
  parameter logic [AXI_ID_WIDTH-1:0]    AXI_ID         = '0,
  parameter bit                         READ_ONLY      = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,

  input  logic                          obi_req_i,
  output logic                          obi_gnt_o,
  input  logic [AXI_ADDR_WIDTH-1:0]     obi_addr_i,
  input  logic                          obi_we_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   obi_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]     obi_wdata_i,
  output logic                          obi_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]     obi_rdata_o,
  output logic                          obi_err_o,

  output logic [AXI_ID_WIDTH-1:0]       aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
  output logic [7:0]                    aw_len_o,
  output logic [2:0]                    aw_size_o,
  output logic [1:0]                    aw_burst_o,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,

  output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
  output logic                          w_last_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,

  input  logic [1:0]                    b_resp_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,

  output logic [AXI_ID_WIDTH-1:0]       ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]     ar_addr_o,
  output logic [7:0]                    ar_len_o,
  output logic [2:0]                    ar_size_o,
  output logic [1:0]                    ar_burst_o,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,

  input  logic [AXI_DATA_WIDTH-1:0]     r_data_i,
  input  logic [1:0]                    r_resp_i,
  input  logic                          r_last_i,
  input  logic                          r_valid_i,
  output logic                          r_ready_o
);

  typedef enum logic [2:0] {
    StIdle, StWr, StWrResp, StRdAddr, StRdData, StErrResp
  } state_e;

  state_e                        state_q;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [AXI_DATA_WIDTH/8-1:0]   be_q;
  logic [AXI_DATA_WIDTH-1:0]     wdata_q;
  logic                          aw_valid_q, w_valid_q, ar_valid_q;
  logic                          b_ready_q, r_ready_q;
  logic                          rvalid_q, err_q;
  logic [AXI_DATA_WIDTH-1:0]     rdata_q;

  // A channel is finished once its valid has dropped or it handshakes this cycle.
  logic aw_fin, w_fin;
  assign aw_fin = !aw_valid_q || aw_ready_i;
  assign w_fin  = !w_valid_q || w_ready_i;

  // Only the SLVERR/DECERR bit of the responses matters; r_last is implied by len=0.
  logic unused_resp;
  assign unused_resp = ^{b_resp_i[0], r_resp_i[0], r_last_i};

  assign obi_gnt_o = obi_req_i && (state_q == StIdle);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (obi_gnt_o) begin
            addr_q  <= obi_addr_i;
            be_q    <= obi_be_i;
            wdata_q <= obi_wdata_i;
            if (obi_we_i) begin
              if (READ_ONLY) begin
                state_q <= StErrResp;
              end else begin
                state_q    <= StWr;
                aw_valid_q <= 1'b1;
                w_valid_q  <= 1'b1;
              end
            end else begin
              state_q    <= StRdAddr;
              ar_valid_q <= 1'b1;
            end
          end
        end
        StWr: begin
          if (aw_valid_q && aw_ready_i) aw_valid_q <= 1'b0;
          if (w_valid_q && w_ready_i)   w_valid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            state_q   <= StWrResp;
            b_ready_q <= 1'b1;
          end
        end
        StWrResp: begin
          if (b_valid_i) begin
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
            err_q     <= b_resp_i[1];
            state_q   <= StIdle;
          end
        end
        StRdAddr: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= StRdData;
          end
        end
        StRdData: begin
          if (r_valid_i) begin
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= r_data_i;
            err_q     <= r_resp_i[1];
            state_q   <= StIdle;
          end
        end
        StErrResp: begin
          rvalid_q <= 1'b1;
          rdata_q  <= '0;
          err_q    <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;

  assign aw_id_o    = AXI_ID;
  assign aw_addr_o  = addr_q;
  assign aw_len_o   = 8'd0;
  assign aw_size_o  = 3'b010;
  assign aw_burst_o = 2'b01;
  assign aw_valid_o = aw_valid_q;

  assign w_data_o  = wdata_q;
  assign w_strb_o  = be_q;
  assign w_last_o  = 1'b1;
  assign w_valid_o = w_valid_q;

  assign b_ready_o = b_ready_q;

  assign ar_id_o    = AXI_ID;
  assign ar_addr_o  = addr_q;
  assign ar_len_o   = 8'd0;
  assign ar_size_o  = 3'b010;
  assign ar_burst_o = 2'b01;
  assign ar_valid_o = ar_valid_q;

  assign r_ready_o = r_ready_q;

endmodule

// File: doc/obi_to_axi_bridge.md
Name: obi_to_axi_bridge

Overview:
- Converts one cv32e40p OBI port (instruction fetch or data) into single-beat AXI4 master transactions driving one slave port of the system crossbar.
- One instance per core port: INSTR instance read-only, DATA instance read/write.
- Strictly one outstanding transaction; OBI response ordering follows trivially.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of OBI and AXI sides.
- AXI_DATA_WIDTH, 32, data width; only 32 supported.
- AXI_ID_WIDTH, 16, AXI ID field width.
- AXI_ID, 0, constant ID driven on aw_id/ar_id.
- READ_ONLY, 0, when 1 writes are granted and answered with err=1, no AXI write issued.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- obi_req_i  in  1  OBI request.
- obi_gnt_o  out  1  OBI grant.
- obi_addr_i  in  AXI_ADDR_WIDTH  byte address.
- obi_we_i  in  1  1=write.
- obi_be_i  in  4  byte enables.
- obi_wdata_i  in  32  write data.
- obi_rvalid_o  out  1  response valid, one-cycle pulse.
- obi_rdata_o  out  32  read data.
- obi_err_o  out  1  error response.
- aw_id_o / aw_addr_o / aw_len_o / aw_size_o / aw_burst_o  out  ID/ADDR/8/3/2  write address.
- aw_valid_o out 1; aw_ready_i in 1.
- w_data_o out 32; w_strb_o out 4; w_last_o out 1; w_valid_o out 1; w_ready_i in 1.
- b_resp_i in 2; b_valid_i in 1; b_ready_o out 1.
- ar_id_o / ar_addr_o / ar_len_o / ar_size_o / ar_burst_o  out  ID/ADDR/8/3/2  read address.
- ar_valid_o out 1; ar_ready_i in 1.
- r_data_i in 32; r_resp_i in 2; r_last_i in 1; r_valid_i in 1; r_ready_o out 1.

Behaviour:
- Constants: len=0, size=3'b010, burst=INCR (2'b01), w_last=1, id=AXI_ID. Addresses passed unaligned-unchanged; strobes = captured be.
- States: IDLE, WR (AW/W pending), WR_RESP, RD_ADDR, RD_DATA, ERR_RESP.
- obi_gnt_o = obi_req_i && state==IDLE (combinational). On gnt, capture addr/we/be/wdata. Next state: write → WR (or ERR_RESP if READ_ONLY); read → RD_ADDR.
- WR: aw_valid and w_valid asserted from the cycle after grant. Each drops independently after its handshake (tracked by aw_done/w_done flags); both done → WR_RESP. Simultaneous handshakes in one cycle allowed.
- WR_RESP: b_ready=1. On b_valid → registered obi_rvalid pulse next cycle, rdata=0, err=b_resp[1]; → IDLE.
- RD_ADDR: ar_valid=1 until ar_ready → RD_DATA.
- RD_DATA: r_ready=1. On r_valid → next cycle rvalid pulse, rdata=r_data, err=r_resp[1]; → IDLE. r_last ignored.
- ERR_RESP: rvalid pulse, err=1, rdata=0; → IDLE.
- Minimum latency with always-ready slave: gnt cycle 0, AX valid cycle 1, B/R valid cycle 2, obi_rvalid cycle 3. New grant possible in cycle 3 (IDLE re-entered with rvalid pulse).
- Valid signals never drop before handshake; payload stable while valid.
- b_ready/r_ready 0 outside response states. Unexpected b_valid/r_valid ignored.
- Reset (any state): state=IDLE, all valid/ready outputs 0, obi_rvalid=0, obi_err=0, obi_rdata=0, captured regs 0. In-flight transaction abandoned.

Test Plan:
- Read 0x0000_0100, slave ready immediately, r_data=0xDEADBEEF, OKAY → ar_addr=0x100, size=2, len=0; obi_rvalid cycle 3, rdata=0xDEADBEEF, err=0.
- Write 0x1000_0004 be=4'b0001 wdata=0x41, aw_ready at cycle 1, w_ready delayed to cycle 4 → aw_valid drops cycle 2, w_valid held through cycle 4 with strb=0x1; rvalid one cycle after b handshake, err=0.
- Read with r_resp=SLVERR (2'b10) → obi_err=1, rvalid single pulse.
- Back-to-back reads, req held high → second gnt only in cycle obi_rvalid of first; no overlap of ar_valid.
- READ_ONLY=1 write to 0x0 → no aw_valid/w_valid ever; rvalid cycle 2 with err=1.
- Assert rst_i while in WR_RESP → all outputs 0 same cycle; after release, new read completes normally.
